mr_lsu: RTL and testbench

// Load/store stage directly downstream of the ALU. Accepts one op per handshake: a computed result or address
// (alu_dest) plus memop, size, signedness and store data. Non-memory ops retire in 1 cycle. Loads/stores run a

---
 rtl/mr_lsu_pkg.sv | 42 ++++
 rtl/mr_lsu_lane.sv | 40 ++++
 rtl/mr_lsu.sv | 178 +++++++++++++++++
 tb/tb_mr_lsu.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr_lsu_pkg.sv
// Shared encodings for the load/store stage: data/regsel widths, memop and size codes
// (common with the ALU and decode stages), fault causes and the LSU state type.
package mr_lsu_pkg;

  localparam int XLEN        = 32;
  localparam int REGSEL_BITS = 5;
  localparam int STRB_W      = XLEN / 8;

  typedef enum logic [1:0] {
    MEMOP_NONE  = 2'd0,
    MEMOP_LOAD  = 2'd1,
    MEMOP_STORE = 2'd2
  } e_memops;

  typedef enum logic [1:0] {
    MEMSZ_B = 2'd0,
    MEMSZ_H = 2'd1,
    MEMSZ_W = 2'd2
  } e_memsz;

  typedef enum logic [1:0] {
    FAULT_MIS_LD = 2'd0,
    FAULT_MIS_ST = 2'd1,
    FAULT_BUS_TO = 2'd2
  } e_ls_fault;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } e_lsu_state;

  // Unknown size codes fall through to word handling, matching the lane logic.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEMSZ_B: return 1'b0;
      MEMSZ_H: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mr_lsu_lane.sv
// Byte-lane steering for the data bus: store strobes and replicated write data,
// and load extraction with sign/zero extension.
module mr_lsu_lane
  import mr_lsu_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [XLEN-1:0]   rd_data_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [XLEN-1:0] rd_shift;

  assign rd_shift = rd_data_i >> {addr_lo_i, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    wstrb_o   = '1;
    wdata_o   = st_data_i;
    ld_data_o = rd_shift;
    case (size_i)
      MEMSZ_B: begin
        wstrb_o   = STRB_W'(1) << addr_lo_i;
        wdata_o   = {STRB_W{st_data_i[7:0]}};
        ld_data_o = {{(XLEN-8){signed_i & rd_shift[7]}}, rd_shift[7:0]};
      end
      MEMSZ_H: begin
        wstrb_o   = STRB_W'(3) << addr_lo_i;
        wdata_o   = {(STRB_W/2){st_data_i[15:0]}};
        ld_data_o = {{(XLEN-16){signed_i & rd_shift[15]}}, rd_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mr_lsu.sv
// Load/store stage: retires ALU results directly, runs one outstanding bus transaction
// for aligned loads/stores, and reports misalignment and bus timeouts as fault pulses.
module mr_lsu
  import mr_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [XLEN-1:0]        alu_dest,
  input  logic [REGSEL_BITS-1:0] alu_dest_reg,
  input  logic [1:0]             alu_memop,
  input  logic [1:0]             alu_size,
  input  logic                   alu_signed,
  input  logic [XLEN-1:0]        alu_payload,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_we,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [STRB_W-1:0]      mem_wstrb,
  input  logic                   mem_resp_valid,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   wb_valid,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic [XLEN-1:0]        wb_data,
  output logic                   ls_fault,
  output logic [1:0]             ls_fault_cause,
  output logic [XLEN-1:0]        ls_fault_addr
);

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  e_lsu_state             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]        addr_q, addr_d;
  logic [REGSEL_BITS-1:0] reg_q, reg_d;
  logic                   we_q, we_d;
  logic [1:0]             size_q, size_d;
  logic                   signed_q, signed_d;
  logic [XLEN-1:0]        payload_q, payload_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [REGSEL_BITS-1:0] wb_reg_q, wb_reg_d;
  logic [XLEN-1:0]        wb_data_q, wb_data_d;
  logic                   fault_q, fault_d;
  e_ls_fault              cause_q, cause_d;
  logic [XLEN-1:0]        fault_addr_q, fault_addr_d;
  logic [XLEN-1:0]        ld_data;
  logic                   is_mem_op;

  mr_lsu_lane u_lane (
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .st_data_i (payload_q),
    .rd_data_i (mem_rdata),
    .wstrb_o   (mem_wstrb),
    .wdata_o   (mem_wdata),
    .ld_data_o (ld_data)
  );

  assign is_mem_op = (alu_memop == MEMOP_LOAD) || (alu_memop == MEMOP_STORE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    reg_d        = reg_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    payload_d    = payload_q;
    wb_valid_d   = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      LSU_IDLE: begin
        if (alu_valid) begin
          if (!is_mem_op) begin
            wb_valid_d = 1'b1;
            wb_reg_d   = alu_dest_reg;
            wb_data_d  = alu_dest;
          end else if (is_misaligned(alu_size, alu_dest[1:0])) begin
            fault_d      = 1'b1;
            cause_d      = (alu_memop == MEMOP_LOAD) ? FAULT_MIS_LD : FAULT_MIS_ST;
            fault_addr_d = alu_dest;
          end else begin
            addr_d    = alu_dest;
            reg_d     = alu_dest_reg;
            we_d      = (alu_memop == MEMOP_STORE);
            size_d    = alu_size;
            signed_d  = alu_signed;
            payload_d = alu_payload;
            state_d   = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          if (we_q) begin
            wb_valid_d = 1'b1;
            wb_reg_d   = '0;
            wb_data_d  = addr_q;
            state_d    = LSU_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        // A response in the final counted cycle still wins over the timeout.
        if (mem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_reg_d   = reg_q;
          wb_data_d  = ld_data;
          state_d    = LSU_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          fault_d      = 1'b1;
          cause_d      = FAULT_BUS_TO;
          fault_addr_d = addr_q;
          state_d      = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      fault_q    <= fault_d;
    end
  end

  // NOTE: datapath registers are only meaningful under a valid/state qualifier, so they carry no reset.
  always_ff @(posedge clk) begin
    addr_q       <= addr_d;
    reg_q        <= reg_d;
    we_q         <= we_d;
    size_q       <= size_d;
    signed_q     <= signed_d;
    payload_q    <= payload_d;
    wb_reg_q     <= wb_reg_d;
    wb_data_q    <= wb_data_d;
    cause_q      <= cause_d;
    fault_addr_q <= fault_addr_d;
  end

  assign alu_ready      = (state_q == LSU_IDLE);
  assign mem_req_valid  = (state_q == LSU_REQ);
  assign mem_we         = we_q;
  assign mem_addr       = {addr_q[XLEN-1:2], 2'b00};
  assign wb_valid       = wb_valid_q;
  assign wb_reg         = wb_reg_q;
  assign wb_data        = wb_data_q;
  assign ls_fault       = fault_q;
  assign ls_fault_cause = cause_q;
  assign ls_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mr_lsu.sv
// Randomized bench for mr_lsu: a byte-level reference model predicts bus fields and
// retire/fault events with their cycle; a single compare process checks every cycle.
module tb_mr_lsu;
  import mr_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, alu_signed;
  logic [31:0] alu_dest, alu_payload;
  logic [4:0]  alu_dest_reg;
  logic [1:0]  alu_memop, alu_size;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, ls_fault;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, ls_fault_addr;
  logic [1:0]  ls_fault_cause;

  mr_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
    .alu_dest_reg(alu_dest_reg), .alu_memop(alu_memop), .alu_size(alu_size),
    .alu_signed(alu_signed), .alu_payload(alu_payload),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ls_fault(ls_fault), .ls_fault_cause(ls_fault_cause), .ls_fault_addr(ls_fault_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          is_wb;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          chk_data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } ev_t;

  ev_t         evq[$];
  int          total = 0, bad = 0, cyc = 0, wb_count = 0;
  bit          chk_en = 0, exp_ready = 1, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] last_wb_data, last_faddr, last_req_addr, last_req_wdata;
  logic [3:0]  last_req_wstrb;
  logic [1:0]  last_cause;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- reference model (byte-oriented) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == MEMSZ_B) ? 1 : (sz == MEMSZ_H) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] s = '0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(sz)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = '0;
    int n = nbytes(sz);
    int off = int'(a % 4);
    for (int j = 0; j < n; j++) v[8*j +: 8] = rd[8*(off+j) +: 8];
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic void push_wb(input int c, input logic [4:0] rd, input logic [31:0] d, input bit cd);
    ev_t e;
    e.cyc = c; e.is_wb = 1; e.rd = rd; e.data = d; e.chk_data = cd; e.cause = '0; e.addr = '0;
    evq.push_back(e);
  endfunction

  function automatic void push_fault(input int c, input logic [1:0] cause, input logic [31:0] a);
    ev_t e;
    e.cyc = c; e.is_wb = 0; e.rd = '0; e.data = '0; e.chk_data = 0; e.cause = cause; e.addr = a;
    evq.push_back(e);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    ev_t ev;
    if (chk_en) begin
      check("wb_fault_excl", 32'(wb_valid & ls_fault), 32'd0);
      check("alu_ready", 32'(alu_ready), 32'(exp_ready));
      check("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
      if (mem_req_valid) begin
        last_req_addr  = mem_addr;
        last_req_wstrb = mem_wstrb;
        last_req_wdata = mem_wdata;
        if (exp_req) begin
          check("mem_addr", mem_addr, exp_addr);
          check("mem_we", 32'(mem_we), 32'(exp_we));
          check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
          if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
        end
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        check("evt_stale", 32'(evq[0].cyc), 32'(cyc));
        void'(evq.pop_front());
      end
      if (wb_valid) wb_count++;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        check("wb_valid", 32'(wb_valid), 32'(ev.is_wb));
        check("ls_fault", 32'(ls_fault), 32'(!ev.is_wb));
        if (ev.is_wb) begin
          last_wb_data = wb_data;
          check("wb_reg", 32'(wb_reg), 32'(ev.rd));
          if (ev.chk_data) check("wb_data", wb_data, ev.data);
        end else begin
          last_cause = ls_fault_cause;
          last_faddr = ls_fault_addr;
          check("fault_cause", 32'(ls_fault_cause), 32'(ev.cause));
          check("fault_addr", ls_fault_addr, ev.addr);
        end
      end else begin
        check("wb_valid_quiet", 32'(wb_valid), 32'd0);
        check("ls_fault_quiet", 32'(ls_fault), 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  // Junk ops while busy must never be accepted.
  task automatic alu_noise;
    if (!exp_ready) begin
      alu_valid    = 1'($urandom_range(0, 1));
      alu_memop    = 2'($urandom_range(0, 2));
      alu_size     = 2'($urandom_range(0, 2));
      alu_dest     = $urandom;
      alu_dest_reg = 5'($urandom);
      alu_payload  = $urandom;
    end else begin
      alu_valid = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    alu_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_rdata      = $urandom;
      tick;
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic set_req_exp(input logic [1:0] op, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] pay);
    exp_req   = 1;
    exp_we    = (op == MEMOP_STORE);
    exp_addr  = a - (a % 4);
    exp_wstrb = (sz == MEMSZ_W) ? 4'hF : m_strb(sz, a);
    exp_wdata = m_wdata(sz, pay);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [4:0] rd, input logic [31:0] pay,
                        input int req_dly, input int resp_dly, input logic [31:0] rdata);
    int acc_e, m_e, idle_e;
    alu_valid = 1'b1; alu_memop = op; alu_size = sz; alu_signed = sg;
    alu_dest = a; alu_dest_reg = rd; alu_payload = pay;
    acc_e = cyc + 1;
    if (op == MEMOP_NONE) push_wb(acc_e, rd, a, 1);
    else if (m_misaligned(sz, a))
      push_fault(acc_e, (op == MEMOP_LOAD) ? FAULT_MIS_LD : FAULT_MIS_ST, a);
    tick;
    alu_valid = 1'b0;
    if (op == MEMOP_NONE || m_misaligned(sz, a)) return;
    exp_ready = 0;
    set_req_exp(op, sz, a, pay);
    for (int i = 0; i < req_dly; i++) begin
      alu_noise;
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_rdata      = $urandom;
      tick;
    end
    alu_noise;
    mem_req_ready = 1'b1;
    m_e = cyc + 1;
    tick;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; alu_valid = 1'b0; exp_req = 0;
    if (op == MEMOP_STORE) begin
      push_wb(m_e, 5'd0, 32'd0, 0);
      exp_ready = 1;
      return;
    end
    if (resp_dly < TO) begin
      idle_e = m_e + resp_dly + 1;
      push_wb(idle_e, rd, m_load(sz, sg, a, rdata), 1);
    end else begin
      idle_e = m_e + TO;
      push_fault(idle_e, FAULT_BUS_TO, a);
    end
    for (int k = 0; k < resp_dly; k++) begin
      alu_noise;
      mem_rdata = $urandom;
      tick;
      exp_ready = (cyc >= idle_e);
    end
    alu_noise;
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    tick;
    mem_resp_valid = 1'b0; alu_valid = 1'b0;
    exp_ready = (cyc >= idle_e);
  endtask

  initial begin
    int          wb_before;
    logic [1:0]  op, sz;
    logic [31:0] a;
    int          rdly, sdly;

    rst = 1'b1; alu_valid = 0; alu_memop = 0; alu_size = 0; alu_signed = 0;
    alu_dest = 0; alu_dest_reg = 0; alu_payload = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
    tick;
    chk_en = 1;
    tick;
    rst = 1'b0;
    settle;
    check("reset_alu_ready", 32'(alu_ready), 32'd1);
    check("reset_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_ls_fault", 32'(ls_fault), 32'd0);

    // Three back-to-back non-memory ops.
    wb_before = wb_count;
    for (int i = 0; i < 3; i++) run_op(MEMOP_NONE, MEMSZ_W, 0, 32'h1234, 5'd5, 0, 0, 0, 0);
    tick;
    settle;
    check("add_x3_count", 32'(wb_count - wb_before), 32'd3);
    check("add_x3_data", last_wb_data, 32'h1234);

    // SB 0xAB at 0x1003 with ready delayed 2 cycles.
    last_req_addr = '0; last_req_wstrb = '0; last_req_wdata = '0;
    run_op(MEMOP_STORE, MEMSZ_B, 0, 32'h1003, 5'd9, 32'h0000_00AB, 2, 0, 0);
    settle;
    check("sb_addr", last_req_addr, 32'h1000);
    check("sb_wstrb", 32'(last_req_wstrb), 32'h8);
    check("sb_wdata", last_req_wdata, 32'hABAB_ABAB);

    last_wb_data = '0;
    run_op(MEMOP_LOAD, MEMSZ_B, 1, 32'h2002, 5'd3, 0, 0, 1, 32'h0080_0000);
    settle;
    check("lb_signed", last_wb_data, 32'hFFFF_FF80);
    run_op(MEMOP_LOAD, MEMSZ_B, 0, 32'h2002, 5'd3, 0, 1, 0, 32'h0080_0000);
    settle;
    check("lbu", last_wb_data, 32'h0000_0080);
    run_op(MEMOP_LOAD, MEMSZ_H, 1, 32'h2002, 5'd3, 0, 0, 2, 32'h0080_0000);
    settle;
    check("lh", last_wb_data, 32'h0000_0080);

    last_cause = 2'd3; last_faddr = '0;
    run_op(MEMOP_LOAD, MEMSZ_W, 0, 32'h3001, 5'd4, 0, 0, 0, 0);
    settle;
    check("lw_mis_cause", 32'(last_cause), 32'(FAULT_MIS_LD));
    check("lw_mis_addr", last_faddr, 32'h3001);
    run_op(MEMOP_STORE, MEMSZ_H, 0, 32'h3003, 5'd4, 0, 0, 0, 0);
    settle;
    check("sh_mis_cause", 32'(last_cause), 32'(FAULT_MIS_ST));

    // Timeout: no response for TO cycles, then a late response that must be ignored.
    last_cause = 2'd3;
    run_op(MEMOP_LOAD, MEMSZ_W, 0, 32'h5000, 5'd6, 0, 1, TO + 2, 32'h1234_5678);
    settle;
    check("to_cause", 32'(last_cause), 32'(FAULT_BUS_TO));
    check("to_addr", last_faddr, 32'h5000);
    run_op(MEMOP_LOAD, MEMSZ_W, 0, 32'h5004, 5'd6, 0, 0, TO - 1, 32'hCAFE_F00D);
    settle;
    check("resp_last_cycle", last_wb_data, 32'hCAFE_F00D);

    // Reset while waiting for a load response.
    alu_memop = MEMOP_LOAD; alu_size = MEMSZ_W; alu_dest = 32'h4000; alu_dest_reg = 5'd7;
    alu_signed = 0; alu_payload = 0; alu_valid = 1'b1;
    tick;
    alu_valid = 1'b0; exp_ready = 0;
    set_req_exp(MEMOP_LOAD, MEMSZ_W, 32'h4000, 0);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0; exp_req = 0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; exp_ready = 1;
    settle;
    check("rst_mid_ready", 32'(alu_ready), 32'd1);
    check("rst_mid_req", 32'(mem_req_valid), 32'd0);
    wb_before = wb_count;
    mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    tick;
    mem_resp_valid = 1'b0;
    tick;
    settle;
    check("rst_mid_no_wb", 32'(wb_count - wb_before), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      op = 2'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % nbytes(sz));
      rdly = $urandom_range(0, 3);
      sdly = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      run_op(op, sz, 1'($urandom_range(0, 1)), a, 5'($urandom), $urandom, rdly, sdly, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
    end
    idle_cycles(3);
    settle;
    check("events_drained", 32'(evq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
